stripe_painter: RTL
===================

Name: stripe_painter

Overview:
- Parametrised, pipelined successor to the 24-bit stripe painter.
- Converts a pixel request (frame, subframe, x, y) into a packed RGB value after a fixed latency, qualified by a valid strobe.
- Adds configurable coordinate and channel widths, a configurable stripe period, and a four-mode display state machine stepped by a pulse.
- Mode changes take effect only at frame boundaries.
- Sits between the LED scan/PWM driver and the panel gamma stage.

Parameters:
FRAME_BITS, 16, width of frame counter input
COORD_BITS, 6, width of x and y (must be >= 6)
CHAN_BITS, 8, bits per colour channel (must be >= 5); rgb width is 3*CHAN_BITS
STRIPE_LOG2, 2, stripe period is 2^STRIPE_LOG2 columns
HUE_SHIFT, 2, hue phase = frame[HUE_SHIFT +: 8]; requires HUE_SHIFT+8 <= FRAME_BITS

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
frame  in  FRAME_BITS  animation frame number
subframe  in  8  PWM subframe (pipelined alongside, unused in colour math)
x  in  COORD_BITS  pixel column
y  in  COORD_BITS  pixel row
pix_valid  in  1  request strobe, any cycle, no back-pressure
mode_step  in  1  one-cycle pulse: advance display mode
rgb  out  3*CHAN_BITS  {blue, green, red}
rgb_valid  out  1  rgb qualifier
mode  out  2  current display mode

Behaviour:
- Reset (async assert, sync release): rgb=0, rgb_valid=0, mode=0, pending=0, last_frame=0, all pipeline valids 0.
- Pipeline: 3 stages, fully registered. A request at cycle N gives its result at N+3. rgb_valid is pix_valid delayed 3. Bubbles propagate; rgb is don't-care while rgb_valid=0.
- S1:
  - hue = frame[HUE_SHIFT+:8] - (x>>1), mod 256.
  - ym = (x + y + frame[5:0]) mod 64.
  - dim = ym[5] ? 31-ym[4:0] : ym[4:0].
  - in_stripe = (x mod 2^STRIPE_LOG2 == 0).
- S2: sector = hue[7:5], h = hue[4:0]. Masks use bit0=R, bit1=G, bit2=B. "up" means gdist=h; "down" means gdist=31-h. sdist=31 in all sectors.
  - 0: solid 000, grad 001, up
  - 1: solid 001, grad 010, up
  - 2: solid 010, grad 001, down
  - 3: solid 010, grad 100, up
  - 4: solid 110, grad 001, up
  - 5: solid 101, grad 010, down
  - 6: solid 100, grad 001, down
  - 7: solid 000, grad 100, down
- S3:
  - d' = saturating d - dim (0 if d < dim).
  - Widen the 5-bit value to CHAN_BITS by repeating its bits MSB-first. For CHAN_BITS=8 this gives {d[4:0], d[4:2]}.
  - Per channel: grad mask → grad level; else solid mask → solid level; else 0. A channel that is off-stripe is 0.
- Modes (effect applied in S1, so every pixel uses one consistent mode):
  - 0 STRIPES: normal.
  - 1 FILL: in_stripe forced 1.
  - 2 NODIM: dim forced 0, stripes kept.
  - 3 BLACK: all channels 0.
- Mode FSM:
  - mode_step sets pending. Multiple pulses within one frame count as one.
  - Frame boundary = pix_valid with frame != last_frame. last_frame is updated on every valid request.
  - At a boundary with pending=1: mode = mode+1, wrapping 3→0; pending clears.
  - The boundary pixel itself uses the new mode.
  - A mode_step in the same cycle as a boundary is deferred to the next boundary.
- Reset mid-operation: in-flight results are discarded; rgb_valid=0 from the next edge.

Optional Feature:
PAINTER_FREEZE_EN
- Defined:
  - Adds input port freeze (1 bit).
  - A frame snapshot register loads frame on each frame boundary while freeze=0 and holds while freeze=1.
  - Hue and ym use the snapshot, so animation stops while x/y still scan.
  - Mode stepping still advances on raw frame boundaries.
- Undefined: no freeze port; hue and ym use frame directly.

Test Plan:
- Defaults, mode 0, frame=0x0080, x=0, y=0, pix_valid → 3 cycles later rgb=0x0000FF, rgb_valid=1; no output before that.
- Same frame, x=4, y=0 → rgb=0x0000D6. Same frame, x=1 → rgb=0x000000.
- One mode_step, then a request with frame 0x0080→0x0081 → mode=1. At x=1, y=0, frame=0x0080 → rgb=0x0000F7.
- Three mode_step pulses within one frame → mode advances by exactly 1. Four separate boundary-stepped advances from mode 0 → mode wraps back to 0. Mode 3 → rgb=0 for all x/y.
- Back-to-back valid requests with alternating bubbles → rgb_valid pattern equals pix_valid pattern delayed by exactly 3.
- resetn low while 3 requests are in flight → rgb_valid=0 and rgb=0 immediately; mode=0. First post-reset request → valid exactly 3 cycles later.

Source files
------------

// File: rtl/stripe_painter.sv
// Pipelined stripe painter: maps (frame, x, y) to packed {B,G,R} after three cycles.
// Define PAINTER_FREEZE_EN to add a freeze input that holds the animation phase.
module stripe_painter #(
  parameter int FRAME_BITS  = 16,
  parameter int COORD_BITS  = 6,
  parameter int CHAN_BITS   = 8,
  parameter int STRIPE_LOG2 = 2,
  parameter int HUE_SHIFT   = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [FRAME_BITS-1:0]  frame,
  input  logic [7:0]             subframe,
  input  logic [COORD_BITS-1:0]  x,
  input  logic [COORD_BITS-1:0]  y,
  input  logic                   pix_valid,
`ifdef PAINTER_FREEZE_EN
  input  logic                   freeze,
`endif
  input  logic                   mode_step,
  output logic [3*CHAN_BITS-1:0] rgb,
  output logic                   rgb_valid,
  output logic [1:0]             mode
);

  typedef enum logic [1:0] {
    MODE_STRIPES = 2'd0,
    MODE_FILL    = 2'd1,
    MODE_NODIM   = 2'd2,
    MODE_BLACK   = 2'd3
  } mode_t;

  localparam logic [COORD_BITS-1:0] STRIPE_MASK = COORD_BITS'((1 << STRIPE_LOG2) - 1);

  // Replicates a 5-bit level MSB-first across the full channel width.
  function automatic logic [CHAN_BITS-1:0] widen5(input logic [4:0] d);
    logic [CHAN_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < CHAN_BITS; i++) begin
      w[CHAN_BITS-1-i] = d[4-(i%5)];
    end
    return w;
  endfunction

  mode_t                 r_mode;
  mode_t                 w_modeNext;
  logic                  r_pending;
  logic                  w_pendingNext;
  logic [FRAME_BITS-1:0] r_lastFrame;
  logic                  w_boundary;

  assign w_boundary = pix_valid && (frame != r_lastFrame);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mode      <= MODE_STRIPES;
      r_pending   <= 1'b0;
      r_lastFrame <= '0;
    end else begin
      r_mode    <= w_modeNext;
      r_pending <= w_pendingNext;
      if (pix_valid) begin
        r_lastFrame <= frame;
      end
    end
  end

  // A step arriving on a boundary cycle is held over to the following boundary.
  always_comb begin
    w_modeNext    = r_mode;
    w_pendingNext = r_pending | mode_step;
    if (w_boundary) begin
      w_pendingNext = mode_step;
      if (r_pending) begin
        case (r_mode)
          MODE_STRIPES: w_modeNext = MODE_FILL;
          MODE_FILL:    w_modeNext = MODE_NODIM;
          MODE_NODIM:   w_modeNext = MODE_BLACK;
          default:      w_modeNext = MODE_STRIPES;
        endcase
      end
    end
  end

  assign mode = r_mode;

  logic [7:0] w_huePhase;
  logic [5:0] w_frameLow;

`ifdef PAINTER_FREEZE_EN
  logic [7:0] r_snapHue;
  logic [5:0] r_snapLow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_snapHue <= '0;
      r_snapLow <= '0;
    end else if (w_boundary && !freeze) begin
      r_snapHue <= frame[HUE_SHIFT +: 8];
      r_snapLow <= frame[5:0];
    end
  end

  assign w_huePhase = (w_boundary && !freeze) ? frame[HUE_SHIFT +: 8] : r_snapHue;
  assign w_frameLow = (w_boundary && !freeze) ? frame[5:0] : r_snapLow;
`else
  assign w_huePhase = frame[HUE_SHIFT +: 8];
  assign w_frameLow = frame[5:0];
`endif

  logic [7:0] w_xHalf;
  logic [7:0] w_hue;
  logic [5:0] w_ym;
  logic [4:0] w_dim;
  logic       w_inStripe;

  assign w_xHalf    = 8'(x >> 1);
  assign w_hue      = w_huePhase - w_xHalf;
  assign w_ym       = x[5:0] + y[5:0] + w_frameLow;
  assign w_dim      = w_ym[5] ? (5'd31 - w_ym[4:0]) : w_ym[4:0];
  assign w_inStripe = ((x & STRIPE_MASK) == '0);

  logic       r1Valid;
  logic [7:0] r1Hue;
  logic [4:0] r1Dim;
  logic       r1Stripe;
  logic       r1Black;
  logic [7:0] r1Sub;

  // The mode is folded in here so every pixel sees exactly one mode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r1Valid  <= 1'b0;
      r1Hue    <= '0;
      r1Dim    <= '0;
      r1Stripe <= 1'b0;
      r1Black  <= 1'b0;
      r1Sub    <= '0;
    end else begin
      r1Valid  <= pix_valid;
      r1Hue    <= w_hue;
      r1Dim    <= (w_modeNext == MODE_NODIM) ? 5'd0 : w_dim;
      r1Stripe <= (w_modeNext == MODE_FILL) || w_inStripe;
      r1Black  <= (w_modeNext == MODE_BLACK);
      r1Sub    <= subframe;
    end
  end

  logic [2:0] w_solid;
  logic [2:0] w_grad;
  logic       w_down;
  logic [4:0] w_gdist;

  always_comb begin
    w_solid = 3'b000;
    w_grad  = 3'b001;
    w_down  = 1'b0;
    case (r1Hue[7:5])
      3'd0: begin w_solid = 3'b000; w_grad = 3'b001; w_down = 1'b0; end
      3'd1: begin w_solid = 3'b001; w_grad = 3'b010; w_down = 1'b0; end
      3'd2: begin w_solid = 3'b010; w_grad = 3'b001; w_down = 1'b1; end
      3'd3: begin w_solid = 3'b010; w_grad = 3'b100; w_down = 1'b0; end
      3'd4: begin w_solid = 3'b110; w_grad = 3'b001; w_down = 1'b0; end
      3'd5: begin w_solid = 3'b101; w_grad = 3'b010; w_down = 1'b1; end
      3'd6: begin w_solid = 3'b100; w_grad = 3'b001; w_down = 1'b1; end
      default: begin w_solid = 3'b000; w_grad = 3'b100; w_down = 1'b1; end
    endcase
  end

  assign w_gdist = w_down ? (5'd31 - r1Hue[4:0]) : r1Hue[4:0];

  logic       r2Valid;
  logic [2:0] r2Solid;
  logic [2:0] r2Grad;
  logic [4:0] r2Gdist;
  logic [4:0] r2Dim;
  logic       r2Stripe;
  logic       r2Black;
  logic [7:0] r2Sub;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r2Valid  <= 1'b0;
      r2Solid  <= '0;
      r2Grad   <= '0;
      r2Gdist  <= '0;
      r2Dim    <= '0;
      r2Stripe <= 1'b0;
      r2Black  <= 1'b0;
      r2Sub    <= '0;
    end else begin
      r2Valid  <= r1Valid;
      r2Solid  <= w_solid;
      r2Grad   <= w_grad;
      r2Gdist  <= w_gdist;
      r2Dim    <= r1Dim;
      r2Stripe <= r1Stripe;
      r2Black  <= r1Black;
      r2Sub    <= r1Sub;
    end
  end

  // Subframe travels with the pixel for the downstream PWM stage but has no colour effect.
  logic w_unusedSub;
  assign w_unusedSub = ^r2Sub;

  logic [4:0]             w_gradLevel5;
  logic [4:0]             w_solidLevel5;
  logic [CHAN_BITS-1:0]   w_gradLevel;
  logic [CHAN_BITS-1:0]   w_solidLevel;
  logic [3*CHAN_BITS-1:0] w_rgb;

  assign w_gradLevel5  = (r2Gdist > r2Dim) ? (r2Gdist - r2Dim) : 5'd0;
  assign w_solidLevel5 = 5'd31 - r2Dim;
  assign w_gradLevel   = widen5(w_gradLevel5);
  assign w_solidLevel  = widen5(w_solidLevel5);

  always_comb begin
    w_rgb = '0;
    for (int c = 0; c < 3; c++) begin
      if (r2Black || !r2Stripe) begin
        w_rgb[c*CHAN_BITS +: CHAN_BITS] = '0;
      end else if (r2Grad[c]) begin
        w_rgb[c*CHAN_BITS +: CHAN_BITS] = w_gradLevel;
      end else if (r2Solid[c]) begin
        w_rgb[c*CHAN_BITS +: CHAN_BITS] = w_solidLevel;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= w_rgb;
      rgb_valid <= r2Valid;
    end
  end

endmodule
